// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: state encoding and widths shared by the PLL reset controller
package pll_reset_pkg;
  localparam int RELOCK_W = 8;
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;
endpackage

// File: rtl/reset_sync_bit.sv
// reset_sync_bit: STAGES-flop synchronizer with asynchronous clear to 0
module reset_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset sequencing and lock-qualified system reset generation
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 16,
  parameter int HOLD_CYCLES    = 256,
  parameter int LOCK_TIMEOUT   = 25000,
  parameter int PLL_RST_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pll_locked_i,
  output logic                pll_rst_o,
  output logic                sys_reset_n_o,
  output logic [2:0]          state_o,
  output logic [RELOCK_W-1:0] relock_count_o
);
  localparam int PW = $clog2(PLL_RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t state, state_n;
  logic [PW-1:0] prc, prc_n;
  logic [TW-1:0] toc, toc_n, toc_inc;
  logic [FW-1:0] flc, flc_n;
  logic [HW-1:0] hoc, hoc_n;
  logic [RELOCK_W-1:0] rel, rel_n;
  logic locked_s, pll_rst_d, sys_d;
  reset_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked_i),
    .q     (locked_s)
  );
  assign toc_inc = toc + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= PLL_RST;
      prc           <= '0;
      toc           <= '0;
      flc           <= '0;
      hoc           <= '0;
      rel           <= '0;
      pll_rst_o     <= 1'b1;
      sys_reset_n_o <= 1'b0;
    end else begin
      state         <= state_n;
      prc           <= prc_n;
      toc           <= toc_n;
      flc           <= flc_n;
      hoc           <= hoc_n;
      rel           <= rel_n;
      pll_rst_o     <= pll_rst_d;
      sys_reset_n_o <= sys_d;
    end
  always_comb begin
    state_n = state;
    prc_n   = prc;
    toc_n   = toc;
    flc_n   = flc;
    hoc_n   = hoc;
    rel_n   = rel;
    case (state)
      PLL_RST:
        if (prc == PW'(PLL_RST_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          toc_n   = '0;
        end else prc_n = prc + 1'b1;
      WAIT_LOCK:
        if (locked_s) begin
          state_n = FILTER;
          flc_n   = FW'(1);
        end else if (toc_inc == TW'(LOCK_TIMEOUT)) begin
          state_n = PLL_RST;
          prc_n   = '0;
        end else toc_n = toc_inc;
      FILTER:
        // timeout keeps running here and takes priority over filter completion
        if (toc_inc == TW'(LOCK_TIMEOUT)) begin
          state_n = PLL_RST;
          prc_n   = '0;
        end else begin
          toc_n = toc_inc;
          if (!locked_s) state_n = WAIT_LOCK;
          else if (flc == FW'(LOCK_FILTER)) begin
            state_n = HOLD;
            hoc_n   = '0;
          end else flc_n = flc + 1'b1;
        end
      HOLD:
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          toc_n   = '0;
        end else if (hoc == HW'(HOLD_CYCLES - 1)) state_n = RUN;
        else hoc_n = hoc + 1'b1;
      RUN:
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          toc_n   = '0;
          rel_n   = (rel == '1) ? rel : rel + 1'b1;
        end
      default: begin
        state_n = PLL_RST;
        prc_n   = '0;
      end
    endcase
  end
  always_comb begin
    pll_rst_d = state_n == PLL_RST;
    sys_d     = state_n == RUN;
  end
  assign state_o        = state;
  assign relock_count_o = rel;
endmodule
